// File: rtl/snes_pad_emulator.sv
// Device-side SNES pad: answers reader latch/clock strobes with 16 active-low
// button bits on pad_data. Strobe inputs are synchronized and glitch-filtered.
module snes_pad_emulator #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        pad_latch,
  input  logic        pad_clock,
  output logic        pad_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [4:0]  bit_index
);

  localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Index 0 carries pad_latch (idles low), index 1 carries pad_clock (idles high).
  logic [1:0]             pins;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [CNT_W-1:0]       cnt  [2];
  logic [1:0]             filt;
  logic [1:0]             filt_d;

  state_t      state, state_next;
  logic [15:0] shreg, shreg_next;
  logic [4:0]  index_next;
  logic        start_next, done_next;

  logic        latch_rise, latch_fall, clock_rise;
  logic [15:0] load_value;

  assign pins = {pad_clock, pad_latch};

  // The filtered level only toggles on the cycle after the counter has held
  // FILTER_CYCLES, which gives the fixed SYNC_STAGES + FILTER_CYCLES + 1 latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync[0] <= '0;
      sync[1] <= '1;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      filt    <= 2'b10;
      filt_d  <= 2'b10;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], pins[i]};
        if (sync[i][SYNC_STAGES-1] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(FILTER_CYCLES)) begin
          filt[i] <= sync[i][SYNC_STAGES-1];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      filt_d <= filt;
    end
  end

  assign latch_rise = filt[0] & ~filt_d[0];
  assign latch_fall = ~filt[0] & filt_d[0];
  assign clock_rise = filt[1] & ~filt_d[1];
  assign load_value = {4'b1111, ~buttons};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '1;
      bit_index   <= 5'd16;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      bit_index   <= index_next;
      frame_start <= start_next;
      frame_done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    index_next = bit_index;
    start_next = 1'b0;
    done_next  = 1'b0;
    // A latch rise outranks everything, including a same-cycle clock rise.
    if (latch_rise) begin
      state_next = LOAD;
      shreg_next = load_value;
      index_next = 5'd0;
      start_next = 1'b1;
    end else begin
      unique case (state)
        IDLE: shreg_next = '1;
        LOAD: begin
          shreg_next = load_value;
          if (latch_fall) state_next = SHIFT;
        end
        SHIFT: begin
          if (clock_rise) begin
            shreg_next = {1'b1, shreg[15:1]};
            index_next = bit_index + 5'd1;
            if (bit_index == 5'd15) begin
              done_next  = 1'b1;
              state_next = IDLE;
              shreg_next = '1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pad_data = shreg[0];

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed bench for snes_pad_emulator: acts as an SNES reader with slow strobes
// and checks serial data, frame pulses, bit_index and strobe latency.
module tb_snes_pad_emulator;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] buttons;
  logic        pad_latch;
  logic        pad_clock;
  logic        pad_data;
  logic        frame_start;
  logic        frame_done;
  logic [4:0]  bit_index;

  int vectors = 0;
  int errors  = 0;
  int fs_cnt  = 0;
  int fd_cnt  = 0;

  snes_pad_emulator #(.SYNC_STAGES(2), .FILTER_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .buttons     (buttons),
    .pad_latch   (pad_latch),
    .pad_clock   (pad_clock),
    .pad_data    (pad_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .bit_index   (bit_index)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (frame_start) fs_cnt++;
    if (frame_done)  fd_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic latch_pulse();
    pad_latch = 1'b1;
    wait_cycles(10);
    pad_latch = 1'b0;
    wait_cycles(10);
  endtask

  // Reader samples pad_data as it drives the clock low.
  task automatic clock_pulse(output logic b);
    b = pad_data;
    pad_clock = 1'b0;
    wait_cycles(10);
    pad_clock = 1'b1;
    wait_cycles(10);
  endtask

  task automatic read_bits(input int n, output logic [15:0] s);
    logic b;
    s = '1;
    for (int i = 0; i < n; i++) begin
      clock_pulse(b);
      s[i] = b;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; buttons = '0; pad_latch = 1'b0; pad_clock = 1'b1;
    wait_cycles(3);
    vectors++;
    if ({pad_data, frame_start, frame_done, bit_index} !== {1'b1, 1'b0, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL reset: data/fs/fd/idx = %b %b %b %0d, required 1 0 0 16",
               pad_data, frame_start, frame_done, bit_index);
    end
    reset = 1'b0;
    wait_cycles(3);
  endtask

  task automatic test_basic();
    logic [15:0] s;
    int fs0, fd0;
    fs0 = fs_cnt; fd0 = fd_cnt;
    buttons = 12'h000;
    latch_pulse();
    vectors++;
    if (bit_index !== 5'd0) begin
      errors++; $display("FAIL basic_index0: got %0d, required 0", bit_index);
    end
    read_bits(16, s);
    vectors++;
    if (s !== 16'hFFFF) begin
      errors++; $display("FAIL basic_data: got %h, required ffff", s);
    end
    vectors++;
    if (fs_cnt - fs0 !== 1 || fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL basic_pulses: fs=%0d fd=%0d, required 1 1", fs_cnt - fs0, fd_cnt - fd0);
    end
    vectors++;
    if (bit_index !== 5'd16 || pad_data !== 1'b1) begin
      errors++; $display("FAIL basic_end: idx=%0d data=%b, required 16 1", bit_index, pad_data);
    end
  endtask

  task automatic test_pattern();
    logic [15:0] s;
    buttons = 12'b1000_0000_0101;
    latch_pulse();
    read_bits(16, s);
    vectors++;
    if (s !== 16'hF7FA) begin
      errors++; $display("FAIL pattern_data: got %h, required f7fa", s);
    end
  endtask

  task automatic test_abort();
    logic [15:0] s;
    int fs0, fd0;
    fs0 = fs_cnt; fd0 = fd_cnt;
    buttons = 12'h001;
    latch_pulse();
    read_bits(5, s);
    vectors++;
    if (fd_cnt - fd0 !== 0 || bit_index !== 5'd5) begin
      errors++; $display("FAIL abort_partial: fd=%0d idx=%0d, required 0 5", fd_cnt - fd0, bit_index);
    end
    buttons = 12'h002;
    latch_pulse();
    read_bits(16, s);
    vectors++;
    if (s !== 16'hFFFD) begin
      errors++; $display("FAIL abort_data: got %h, required fffd", s);
    end
    vectors++;
    if (fs_cnt - fs0 !== 2 || fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL abort_pulses: fs=%0d fd=%0d, required 2 1", fs_cnt - fs0, fd_cnt - fd0);
    end
  endtask

  task automatic test_overclock();
    logic b;
    int bad;
    int fd0;
    bad = 0; fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      clock_pulse(b);
      if (b !== 1'b1 || pad_data !== 1'b1 || bit_index !== 5'd16) bad++;
    end
    vectors++;
    if (bad !== 0 || fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL overclock: bad=%0d fd=%0d idx=%0d, required 0 0 16", bad, fd_cnt - fd0, bit_index);
    end
  endtask

  task automatic test_latency();
    logic [15:0] s;
    logic [5:0]  trace;
    logic [4:0]  idx5, idx6;
    buttons = 12'h001;
    latch_pulse();
    vectors++;
    if (pad_data !== 1'b0) begin
      errors++; $display("FAIL latency_bit0: got %b, required 0", pad_data);
    end
    pad_clock = 1'b0;
    wait_cycles(10);
    pad_clock = 1'b1;
    idx5 = '0; idx6 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      trace[k] = pad_data;
      if (k == 4) idx5 = bit_index;
      if (k == 5) idx6 = bit_index;
    end
    vectors++;
    if (trace !== 6'b100000) begin
      errors++; $display("FAIL latency_data: trace=%b, required 100000", trace);
    end
    vectors++;
    if (idx5 !== 5'd0 || idx6 !== 5'd1) begin
      errors++; $display("FAIL latency_index: %0d %0d, required 0 1", idx5, idx6);
    end
    wait_cycles(4);
    read_bits(15, s);
  endtask

  task automatic test_glitch();
    logic [15:0] s;
    int fs0;
    buttons = 12'h805;
    latch_pulse();
    read_bits(3, s);
    fs0 = fs_cnt;
    pad_latch = 1'b1;
    wait_cycles(1);
    pad_latch = 1'b0;
    wait_cycles(3);
    pad_clock = 1'b0;
    wait_cycles(1);
    pad_clock = 1'b1;
    wait_cycles(10);
    vectors++;
    if (fs_cnt - fs0 !== 0 || bit_index !== 5'd3 || pad_data !== 1'b1) begin
      errors++; $display("FAIL glitch: fs=%0d idx=%0d data=%b, required 0 3 1", fs_cnt - fs0, bit_index, pad_data);
    end
    read_bits(13, s);
  endtask

  task automatic test_latch_vs_clock();
    logic [15:0] s;
    int fs0;
    buttons = 12'h0F0;
    latch_pulse();
    read_bits(2, s);
    fs0 = fs_cnt;
    pad_clock = 1'b0;
    wait_cycles(10);
    pad_latch = 1'b1;
    pad_clock = 1'b1;
    wait_cycles(10);
    vectors++;
    if (bit_index !== 5'd0 || fs_cnt - fs0 !== 1) begin
      errors++; $display("FAIL latch_vs_clock: idx=%0d fs=%0d, required 0 1", bit_index, fs_cnt - fs0);
    end
    pad_latch = 1'b0;
    wait_cycles(10);
    read_bits(16, s);
    vectors++;
    if (s !== 16'hFF0F) begin
      errors++; $display("FAIL latch_vs_clock_data: got %h, required ff0f", s);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] s;
    logic b;
    int fd0;
    buttons = 12'h805;
    latch_pulse();
    read_bits(7, s);
    vectors++;
    if (bit_index !== 5'd7) begin
      errors++; $display("FAIL midframe_index: got %0d, required 7", bit_index);
    end
    reset = 1'b1;
    wait_cycles(1);
    vectors++;
    if (pad_data !== 1'b1 || bit_index !== 5'd16) begin
      errors++; $display("FAIL midframe_reset: data=%b idx=%0d, required 1 16", pad_data, bit_index);
    end
    reset = 1'b0;
    wait_cycles(2);
    clock_pulse(b);
    vectors++;
    if (bit_index !== 5'd16 || pad_data !== 1'b1) begin
      errors++; $display("FAIL midframe_idle: idx=%0d data=%b, required 16 1", bit_index, pad_data);
    end
    fd0 = fd_cnt;
    latch_pulse();
    read_bits(16, s);
    vectors++;
    if (s !== 16'hF7FA || fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL midframe_next: data=%h fd=%0d, required f7fa 1", s, fd_cnt - fd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_abort();
    test_overclock();
    test_latency();
    test_glitch();
    test_latch_vs_clock();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/snes_pad_emulator.md
Name: snes_pad_emulator

Overview:
- Device-side SNES controller emulator: answers a console or host reader's latch/clock strobes by shifting out 16 button bits on a serial data line, active-low.
- Lets the FPGA present a virtual pad to an SNES-protocol reader, for example a real SNES or a bench loopback against our reader.
- Button source is a parallel active-high vector (keyboard, UART or test logic).
- Runs on the fast system clock; pad_latch and pad_clock are asynchronous inputs, synchronized and glitch-filtered internally.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on pad_latch and pad_clock. Minimum 2.
- FILTER_CYCLES, 2: consecutive cycles a synchronized level must differ from the filtered level before it is accepted. Minimum 1.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: reset, synchronous, active-high; clock clock.
- buttons, input, 12: 1 = pressed. Index 0..11 = B Y SELECT START UP DOWN LEFT RIGHT A X L R.
- pad_latch, input, 1: async latch from the reader; idle low.
- pad_clock, input, 1: async serial clock from the reader; idle high.
- pad_data, output, 1: serial button data; 0 = pressed; idle 1.
- frame_start, output, 1: one-cycle pulse on accepted latch rise.
- frame_done, output, 1: one-cycle pulse when the 16th bit has been shifted past.
- bit_index, output, 5: index of the bit currently on pad_data, 0..16; 16 = exhausted.

Behaviour:
- Reset values:
  - Synchronizer and filtered latch = 0; synchronizer and filtered clock = 1.
  - shreg = 16'hFFFF, bit_index = 16, state = IDLE.
  - pad_data = 1, frame_start = 0, frame_done = 0.
- Edge detection: rise/fall are taken on the filtered signals only. Filter behaviour:
  - The counter increments while sync output != filtered value.
  - It clears when they are equal.
  - The filtered value toggles when the counter reaches FILTER_CYCLES.
- Latency: from the first clock edge that samples a new pin level to the pad_data/bit_index update is SYNC_STAGES + FILTER_CYCLES + 1 cycles (5 at defaults). This is a fixed requirement.
- Reader constraint: pad_latch pulse width and pad_clock half-period must be at least latency + 2 cycles.
- shreg load value = {4'b1111, ~buttons}. Bits 12-15 are the standard-pad ID and are always 1.
- pad_data is registered and always equals shreg[0].
- States:
  - IDLE: pad_data = 1, pad_clock edges ignored. Latch rise -> LOAD.
  - LOAD (latch high):
    - On entry: frame_start = 1 for one cycle, bit_index = 0.
    - Every cycle: shreg reloads from buttons, so the last value before latch fall wins.
    - pad_clock edges are ignored.
    - Latch fall -> SHIFT, with shreg holding the final load and pad_data = ~buttons[0].
  - SHIFT: on each filtered pad_clock rise:
    - shreg shifts right with 1 filled into the MSB, and bit_index increments.
    - When bit_index becomes 16: frame_done = 1 for one cycle, pad_data = 1, -> IDLE.
    - pad_clock falls change nothing; the reader samples on the fall.
- Latch rise in any state (including mid-SHIFT): abort the frame, no frame_done, -> LOAD.
- Extra pad_clock rises after 16 bits: pad_data stays 1 and bit_index stays 16, with no wrap.
- Latch rise and clock rise accepted in the same cycle: latch wins, clock rise is discarded.
- buttons changes during SHIFT do not affect the frame in progress.
- reset asserted mid-frame: everything returns to reset values on the next edge. A latch held high across reset deassertion produces a frame_start only after the filter sees it rise; the filtered latch reset value is 0.

Test Plan:
1. Basic frame: reset, buttons = 0, then latch pulse and 16 clock pulses -> pad_data = 1 on all 16 samples. frame_start once, frame_done once after the 16th rise, bit_index ends at 16.
2. Pattern: buttons = 12'b1000_0000_0101 (B, SELECT, R), frame -> samples taken at each pad_clock fall read 0,1,0,1,1,1,1,1,1,1,1,0,1,1,1,1.
3. Abort: buttons = 12'h001, latch, 5 clocks, then latch again with buttons = 12'h002, 16 clocks -> no frame_done after the first burst. The second frame reads 1,0,1,... and frame_done = 1 exactly once.
4. Over-clocking and latency: after 16 bits, 4 extra clocks -> pad_data = 1 and bit_index = 16 throughout. With defaults, each pad_data change lands exactly 5 cycles after the first clock edge sampling the pad_clock rise.
5. Glitch rejection: a 1-cycle high pulse on pad_latch and a 1-cycle low pulse on pad_clock during SHIFT -> no frame_start, bit_index unchanged.
6. Reset mid-frame: assert reset at bit_index = 7 -> pad_data = 1, bit_index = 16, state IDLE. Next full frame reads the correct pattern.
